// File: rtl/riscv_pkg.sv
// Core-wide types and constants shared by fetch, decode and later stages.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries between instruction memory and decode.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic            do_pop;

    assign do_pop = pop && (count != '0);
    assign head   = mem[rptr];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + PW'(1);
            if (do_pop)
                rptr <= rptr + PW'(1);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC generation, credit-limited memory requests,
// redirect handling with in-flight response dropping, and the decode queue.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   q_count;
    logic [CW:0]     in_use;
    logic [XLEN-1:0] target_pc;
    logic            req_fire;
    logic            resp_keep;
    logic            q_pop;
    fetch_entry_t    q_head;
    fetch_entry_t    q_in;

    assign in_use         = {1'b0, outstanding} + {1'b0, q_count};
    assign imem_req_valid = rst_n && !redirect_valid && (in_use < (CW+1)'(DEPTH));
    assign imem_addr      = req_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign resp_keep      = imem_resp_valid && (drop_cnt == '0) && !redirect_valid;
    assign target_pc      = redirect_pc & ~32'h0000_0003;
    assign q_in           = '{instr: imem_resp_data, pc: resp_pc};

    assign instr_valid = (q_count != '0);
    assign q_pop       = instr_valid && instr_ready && !redirect_valid;
    assign instr       = instr_valid ? q_head.instr : INSTR_NOP;
    assign instr_pc    = instr_valid ? q_head.pc    : RESET_PC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_pc      <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
            if (redirect_valid) begin
                req_pc   <= target_pc;
                resp_pc  <= target_pc;
                // Every in-flight response is stale; outstanding already
                // includes any pending drops, so this also covers accumulation.
                drop_cnt <= outstanding - CW'(imem_resp_valid);
            end else begin
                if (req_fire)
                    req_pc <= req_pc + 32'd4;
                if (resp_keep)
                    resp_pc <= resp_pc + 32'd4;
                if (imem_resp_valid && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (resp_keep),
        .push_data (q_in),
        .pop       (q_pop),
        .flush     (redirect_valid),
        .head      (q_head),
        .count     (q_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1-cycle in-order instruction memory model.
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        mem_en;
    logic [31:0] pending[$];
    logic [31:0] exp_pc;
    int          tests = 0;
    int          fails = 0;
    int          n_acc;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // Memory returns ~addr, in order, one cycle after acceptance at the earliest.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending.delete();
            imem_resp_valid <= 1'b0;
            imem_resp_data  <= '0;
        end else begin
            if (mem_en && pending.size() > 0) begin
                imem_resp_valid <= 1'b1;
                imem_resp_data  <= ~pending[0];
                void'(pending.pop_front());
            end else begin
                imem_resp_valid <= 1'b0;
            end
            if (imem_req_valid && imem_req_ready)
                pending.push_back(imem_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, got, expv);
        end
    endtask

    task automatic take(input string tag);
        if (instr_valid && instr_ready) begin
            chk({tag, "_pc"}, instr_pc, exp_pc);
            chk({tag, "_instr"}, instr, ~exp_pc);
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            take(tag);
        end
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        #1;
        chk1("redir_reqv_suppressed", imem_req_valid, 1'b0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_en         = 1'b1;
        exp_pc         = '0;

        // Reset values
        #1;
        chk1("rst_reqv", imem_req_valid, 1'b0);
        chk("rst_addr", imem_addr, 32'h0);
        chk1("rst_ivalid", instr_valid, 1'b0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_ipc", instr_pc, 32'h0);
        repeat (3) @(negedge clk);

        // Streaming fill: one request per cycle, first instruction after 3 cycles
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 11; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            chk("fill_addr", imem_addr, 32'(4 * k));
            chk1("fill_reqv", imem_req_valid, 1'b1);
            chk1("fill_ivalid", instr_valid, (k >= 3));
            take("fill");
        end

        // Decode stalls for 10 cycles
        @(negedge clk);
        instr_ready = 1'b0;
        n_acc = 0;
        for (int s = 0; s < 10; s++) begin
            if (s != 0) @(negedge clk);
            #1;
            chk1("stall_ivalid", instr_valid, 1'b1);
            chk("stall_head_pc", instr_pc, 32'h20);
            chk("stall_head_instr", instr, ~32'h20);
            if (imem_req_valid && imem_req_ready) n_acc++;
        end
        chk1("stall_reqv_dropped", imem_req_valid, 1'b0);
        chk1("stall_req_cap", (n_acc <= DEPTH), 1'b1);

        @(negedge clk);
        instr_ready = 1'b1;
        #1;
        take("resume");
        run("resume", 11);
        chk1("resume_progress", (exp_pc >= 32'd48), 1'b1);

        // Drain: memory stops accepting
        @(negedge clk);
        imem_req_ready = 1'b0;
        #1;
        take("drain");
        run("drain", 7);
        chk1("drain_ivalid", instr_valid, 1'b0);
        chk1("drain_reqv", imem_req_valid, 1'b1);
        chk("drain_addr", imem_addr, exp_pc);

        // Redirect to 0x100 with two requests outstanding
        @(negedge clk);
        mem_en = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        chk("rd1_addr0", imem_addr, exp_pc);
        @(negedge clk);
        #1;
        chk("rd1_addr1", imem_addr, exp_pc + 32'd4);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        #1;
        chk1("rd1_reqv_suppressed", imem_req_valid, 1'b0);
        @(negedge clk);
        redirect_valid = 1'b0;
        mem_en = 1'b1;
        #1;
        chk("rd1_addr", imem_addr, 32'h100);
        chk1("rd1_reqv", imem_req_valid, 1'b1);
        chk1("rd1_ivalid", instr_valid, 1'b0);
        exp_pc = 32'h100;
        run("rd1", 10);
        chk1("rd1_progress", (exp_pc >= 32'h110), 1'b1);

        // Redirect coinciding with a response and a pop
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        #1;
        chk1("rd2_pre_ivalid", instr_valid, 1'b1);
        chk1("rd2_pre_resp", imem_resp_valid, 1'b1);
        chk1("rd2_reqv_suppressed", imem_req_valid, 1'b0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk1("rd2_ivalid_n1", instr_valid, 1'b0);
        chk("rd2_addr", imem_addr, 32'h200);
        chk1("rd2_reqv", imem_req_valid, 1'b1);
        @(negedge clk);
        #1;
        chk1("rd2_ivalid_n2", instr_valid, 1'b0);
        exp_pc = 32'h200;
        run("rd2", 10);
        chk1("rd2_progress", (exp_pc >= 32'h210), 1'b1);

        // PC wrap from 0xFFFF_FFFC
        do_redirect(32'hFFFF_FFFC);
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        #1;
        chk("wrap_addr1", imem_addr, 32'h0);
        exp_pc = 32'hFFFF_FFFC;
        run("wrap", 8);
        chk1("wrap_progress", (exp_pc < 32'h100), 1'b1);

        // Misaligned redirect target
        do_redirect(32'h0000_0103);
        chk("misalign_addr", imem_addr, 32'h100);
        exp_pc = 32'h100;
        run("misalign", 8);
        chk1("misalign_progress", (exp_pc >= 32'h108), 1'b1);

        // Asynchronous reset mid-burst
        @(negedge clk);
        #1;
        chk1("arst_pre_ivalid", instr_valid, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk1("arst_reqv", imem_req_valid, 1'b0);
        chk("arst_addr", imem_addr, 32'h0);
        chk1("arst_ivalid", instr_valid, 1'b0);
        chk("arst_instr", instr, 32'h0000_0013);
        chk("arst_ipc", instr_pc, 32'h0);
        repeat (2) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_restart_addr", imem_addr, 32'h0);
        chk1("arst_restart_reqv", imem_req_valid, 1'b1);
        exp_pc = 32'h0;
        run("arst", 8);
        chk1("arst_progress", (exp_pc >= 32'd16), 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
